// File: rtl/i2c_codec_target.sv
// I2C write-only target for a codec: a 3-byte write {dev,W} {reg[6:0],d[8]} {d[7:0]} produces one 9-bit register write.
// Define I2C_TARGET_REGFILE_EN to keep the written values in an NREGS-entry register file readable via rd_addr/rd_data.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NREGS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ACK_ADDR = 3'd2;
    localparam logic [2:0] REG      = 3'd3;
    localparam logic [2:0] ACK_REG  = 3'd4;
    localparam logic [2:0] DATA     = 3'd5;
    localparam logic [2:0] ACK_DATA = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       addr_match;
    logic       oe_q;
    logic [6:0] reg_addr;
    logic       data_msb;
    logic       vld_p0;
    logic [6:0] addr_p0;
    logic [8:0] data_p0;
    logic       wr_commit;

    // Stage p0/p1: two-flop synchronizers; p2 keeps the previous synchronized sample for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_p0, scl_p1, scl_p2} <= 3'b111;
            {sda_p0, sda_p1, sda_p2} <= 3'b111;
        end else begin
            scl_p0 <= i2c_sclk;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= i2c_sdat_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise   = scl_p1 & ~scl_p2;
    assign scl_fall   = ~scl_p1 & scl_p2;
    assign start_det  = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop_det   = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
    assign rx_byte    = {shift, sda_p1};
    assign byte_done  = scl_rise && (bit_cnt == 3'd7);
    assign addr_match = (rx_byte[7:1] == DEV_ADDR) && !rx_byte[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            oe_q    <= 1'b0;
            busy    <= 1'b0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                oe_q    <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state <= IDLE;
                oe_q  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ADDR, REG, DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    if (addr_match) begin
                                        state <= ACK_ADDR;
                                        busy  <= 1'b1;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end else if (state == REG) begin
                                    state <= ACK_REG;
                                end else begin
                                    state  <= ACK_DATA;
                                    vld_p0 <= 1'b1;
                                end
                            end
                        end
                    end
                    // First SCL fall after bit 8 pulls SDA low; the next fall releases it and moves on
                    ACK_ADDR, ACK_REG, ACK_DATA: begin
                        if (scl_fall) begin
                            oe_q <= ~oe_q;
                            if (oe_q) begin
                                state <= (state == ACK_ADDR) ? REG :
                                         (state == ACK_REG)  ? DATA : IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (scl_rise) shift <= {shift[5:0], sda_p1};
        if (state == REG && byte_done) begin
            reg_addr <= rx_byte[7:1];
            data_msb <= rx_byte[0];
        end
        if (state == DATA && byte_done) begin
            addr_p0 <= reg_addr;
            data_p0 <= {data_msb, rx_byte};
        end
    end

    // Stage p1: publish the completed write; a START/STOP arriving in the gap cancels it
    assign wr_commit = vld_p0 & ~start_det & ~stop_det;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_addr  <= 7'd0;
            wr_data  <= 9'd0;
        end else begin
            wr_valid <= wr_commit;
            if (wr_commit) begin
                wr_addr <= addr_p0;
                wr_data <= data_p0;
            end
        end
    end

    // Gated with reset so SDA is released in the very cycle reset is applied
    assign i2c_sdat_oe = oe_q & ~reset;

`ifdef I2C_TARGET_REGFILE_EN
    localparam int         AW        = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [7:0] NREGS_LIM = 8'(NREGS);

    logic [8:0] regs [2**AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) regs[i] <= 9'd0;
            rd_data <= 9'd0;
        end else begin
            if (wr_commit && ({1'b0, addr_p0} < NREGS_LIM)) regs[addr_p0[AW-1:0]] <= data_p0;
            rd_data <= ({1'b0, rd_addr} < NREGS_LIM) ? regs[rd_addr[AW-1:0]] : 9'd0;
        end
    end
`else
    localparam int unused_nregs = NREGS;
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = 9'd0;
`endif

endmodule
